// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Ethernet TX frame arbiter:
//   arb_state_t  - arbiter FSM states (idle / forwarding a frame / discarding
//                  the tail of a truncated frame)
//   BEAT_CNT_W   - width of the per-frame beat counter
// ---------------------------------------------------------------------------
package eth_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACTIVE = 2'd1,
        ARB_DROP   = 2'd2
    } arb_state_t;

    localparam int BEAT_CNT_W = 16;

endpackage

// File: rtl/eth_rr_prio.sv
// ---------------------------------------------------------------------------
// eth_rr_prio
// Purely combinational round-robin selector. Picks the first asserted request
// at or after ptr, wrapping modulo N.
// Ports:
//   req       in  [N-1:0]      request vector
//   ptr       in  [PTR_W-1:0]  highest-priority index (must be < N)
//   gnt       out [N-1:0]      one-hot grant, all zero when no request
//   gnt_valid out              at least one request present
// ---------------------------------------------------------------------------
module eth_rr_prio #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid
);

    logic [2*N-1:0] req_shift;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   pick_rot;
    logic [2*N-1:0] gnt_shift;

    // Rotate requests so that index ptr lands at bit 0; the doubled vector
    // makes the rotation a plain shift.
    assign req_shift = {req, req} >> ptr;
    assign req_rot   = req_shift[N-1:0];

    // Isolate the lowest set bit of the rotated vector.
    assign pick_rot  = req_rot & (~req_rot + N'(1));

    // Rotate back: bit j of pick_rot is request (ptr + j) mod N, which ends up
    // in the upper half of the doubled, left-shifted vector.
    assign gnt_shift = {pick_rot, pick_rot} << ptr;
    assign gnt       = gnt_shift[2*N-1:N];
    assign gnt_valid = |req;

endmodule

// File: rtl/eth_tx_frame_arb.sv
// ---------------------------------------------------------------------------
// eth_tx_frame_arb
// Round-robin arbiter merging S_COUNT byte-wide AXI-Stream requesters into a
// single MAC tx_axis stream. A granted requester owns the output for a whole
// frame. Frames longer than MAX_FRAME_LEN beats are cut: the last permitted
// beat is marked tlast+tuser (bad frame) and the rest of the input frame is
// swallowed.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   s_axis_tdata [S_COUNT*8]     requester bytes, port i at [8i+7:8i]
//   s_axis_tvalid/tlast/tuser    per-requester sideband [S_COUNT]
//   s_axis_tready [S_COUNT]      per-requester ready (only owner may be high)
//   m_axis_tdata/tvalid/tlast/tuser, m_axis_tready   MAC tx_axis
//   grant [S_COUNT]              one-hot current owner, 0 when idle
//   busy                         a frame is being forwarded or dropped
//   frame_trunc                  pulse on the transfer of a truncated beat
// ---------------------------------------------------------------------------
module eth_tx_frame_arb
    import eth_pkg::*;
#(
    parameter int S_COUNT       = 4,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [S_COUNT*8-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]   s_axis_tvalid,
    input  logic [S_COUNT-1:0]   s_axis_tlast,
    input  logic [S_COUNT-1:0]   s_axis_tuser,
    output logic [S_COUNT-1:0]   s_axis_tready,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    input  logic                 m_axis_tready,
    output logic [S_COUNT-1:0]   grant,
    output logic                 busy,
    output logic                 frame_trunc
);

    localparam int PTR_W = $clog2(S_COUNT);
    // Counter value seen while the MAX_FRAME_LEN-th beat is on the bus.
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT_IDX = BEAT_CNT_W'(MAX_FRAME_LEN - 1);

    arb_state_t              state_reg, state_next;
    logic [S_COUNT-1:0]      grant_reg, grant_next;
    logic [PTR_W-1:0]        rr_ptr_reg, rr_ptr_next;
    logic [BEAT_CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;

    logic [S_COUNT-1:0]      rr_gnt;
    logic                    rr_valid;

    logic [7:0]              data_masked [S_COUNT];
    logic [7:0]              sel_tdata;
    logic                    sel_tvalid;
    logic                    sel_tlast;
    logic                    sel_tuser;
    logic [PTR_W-1:0]        grant_idx;
    logic [PTR_W-1:0]        ptr_after;
    logic                    trunc_beat;
    logic                    m_xfer;

    eth_rr_prio #(
        .N     (S_COUNT),
        .PTR_W (PTR_W)
    ) u_rr_prio (
        .req       (s_axis_tvalid),
        .ptr       (rr_ptr_reg),
        .gnt       (rr_gnt),
        .gnt_valid (rr_valid)
    );

    // AND-OR mux driven by the registered one-hot grant; zero when no grant.
    generate
        for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_port_mask
            assign data_masked[gi] = grant_reg[gi] ? s_axis_tdata[gi*8 +: 8] : 8'd0;
        end
    endgenerate

    always_comb begin
        sel_tdata = 8'd0;
        for (int i = 0; i < S_COUNT; i++) begin
            sel_tdata = sel_tdata | data_masked[i];
        end
    end

    assign sel_tvalid = |(s_axis_tvalid & grant_reg);
    assign sel_tlast  = |(s_axis_tlast  & grant_reg);
    assign sel_tuser  = |(s_axis_tuser  & grant_reg);

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_reg[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

    // Next round-robin start: one past the port that just finished.
    assign ptr_after = (grant_idx == PTR_W'(S_COUNT - 1)) ? '0 : grant_idx + PTR_W'(1);

    // A beat at the length limit that is not the input's own last beat must be
    // cut. Independent of m_axis_tready so tvalid/tlast stay ready-agnostic.
    assign trunc_beat = (beat_cnt_reg == LAST_BEAT_IDX) && !sel_tlast;
    assign m_xfer     = (state_reg == ARB_ACTIVE) && sel_tvalid && m_axis_tready;

    assign grant = grant_reg;
    assign busy  = (state_reg != ARB_IDLE);

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        m_axis_tdata  = 8'd0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        frame_trunc   = 1'b0;

        case (state_reg)
            ARB_IDLE: begin
                if (rr_valid) begin
                    grant_next    = rr_gnt;
                    beat_cnt_next = '0;
                    state_next    = ARB_ACTIVE;
                end
            end

            ARB_ACTIVE: begin
                m_axis_tdata  = sel_tdata;
                m_axis_tvalid = sel_tvalid;
                m_axis_tlast  = sel_tlast | trunc_beat;
                m_axis_tuser  = sel_tuser | trunc_beat;
                s_axis_tready = grant_reg & {S_COUNT{m_axis_tready}};
                if (m_xfer) begin
                    beat_cnt_next = beat_cnt_reg + BEAT_CNT_W'(1);
                    if (sel_tlast) begin
                        state_next  = ARB_IDLE;
                        grant_next  = '0;
                        rr_ptr_next = ptr_after;
                    end else if (trunc_beat) begin
                        frame_trunc = 1'b1;
                        state_next  = ARB_DROP;
                    end
                end
            end

            ARB_DROP: begin
                // Owner keeps draining into the void until its own tlast.
                s_axis_tready = grant_reg;
                if (sel_tvalid && sel_tlast) begin
                    state_next  = ARB_IDLE;
                    grant_next  = '0;
                    rr_ptr_next = ptr_after;
                end
            end

            default: begin
                state_next = ARB_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ARB_IDLE;
            grant_reg    <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

endmodule

// File: doc/eth_tx_frame_arb.md
ETH_TX_FRAME_ARB -- requirements
Module: eth_tx_frame_arb

Interface
REQ-001 SHALL have parameter S_COUNT, default 4: number of TX requester ports (2..8).
REQ-002 SHALL have parameter MAX_FRAME_LEN, default 1518: maximum beats per frame before forced truncation (64..65535).
REQ-003 SHALL have port clk  input  1  single clock for all logic; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port s_axis_tdata  input  S_COUNT*8  requester bytes, port i at bits [8i+7:8i].
REQ-006 SHALL have ports s_axis_tvalid, s_axis_tlast, s_axis_tuser  input  S_COUNT each  per-requester AXI-Stream sideband.
REQ-007 SHALL have port s_axis_tready  output  S_COUNT  per-requester ready.
REQ-008 SHALL have ports m_axis_tdata (8), m_axis_tvalid, m_axis_tlast, m_axis_tuser  output  to MAC tx_axis.
REQ-009 SHALL have port m_axis_tready  input  1  MAC tx_axis_tready.
REQ-010 SHALL have port grant  output  S_COUNT  one-hot current owner, 0 when idle.
REQ-011 SHALL have port busy  output  1  high in ACTIVE or DROP.
REQ-012 SHALL have port frame_trunc  output  1  one-cycle pulse on forced truncation.

Function
REQ-013 SHALL implement states IDLE, ACTIVE, DROP.
REQ-014 IDLE: when any s_axis_tvalid high, SHALL select the first requesting port at or after rr_ptr (wrapping modulo S_COUNT), register grant, enter ACTIVE next cycle; all s_axis_tready low in IDLE.
REQ-015 ACTIVE: m_axis_tdata/tvalid/tlast/tuser SHALL be combinational mux of granted port; s_axis_tready[g] = m_axis_tready; all other tready low.
REQ-016 Beat counter (16 bit) SHALL increment on each m_axis transfer, clear on entering ACTIVE.
REQ-017 Transfer with input tlast SHALL end frame: state IDLE, grant 0, rr_ptr = g+1 mod S_COUNT, next cycle.
REQ-018 On the MAX_FRAME_LEN-th beat without input tlast, SHALL force m_axis_tlast=1 and m_axis_tuser=1, pulse frame_trunc on that transfer, enter DROP.
REQ-019 Input tlast on exactly the MAX_FRAME_LEN-th beat SHALL be a normal end (no truncation, tuser passed through).
REQ-020 DROP: m_axis_tvalid low; s_axis_tready[g]=1; discard beats; on input tlast transfer enter IDLE, rr_ptr = g+1.
REQ-021 Grant SHALL never change mid-frame regardless of other requests; minimum one IDLE cycle between frames.
REQ-022 Outputs with no grant SHALL be: m_axis_tvalid 0, tdata 0, tlast 0, tuser 0.
REQ-023 m_axis_tvalid SHALL not depend combinationally on m_axis_tready.

Reset
REQ-024 rst SHALL force state IDLE, grant 0, rr_ptr 0, beat counter 0, frame_trunc 0, busy 0, all s_axis_tready 0, m_axis_tvalid 0 on the next clk edge.
REQ-025 Reset mid-frame SHALL abandon the frame without emitting tlast; MAC reset is the integrator's responsibility.

Structure
REQ-026 State enum and beat-counter width constant SHALL live in shared package eth_pkg.
REQ-027 Round-robin selection SHALL be a sub-module eth_rr_prio (request vector, pointer -> one-hot grant, valid), purely combinational.

Verification
REQ-028 Ports 0 and 2 request simultaneously after reset, 10-byte frames -> port 0 frame fully sent first, then port 2; grant 0001 then 0100.
REQ-029 All 4 ports continuously request 3 frames each -> output order 0,1,2,3,0,1,2,3,0,1,2,3, no interleaved bytes.
REQ-030 MAX_FRAME_LEN=64, port 1 sends 100-beat frame -> 64 beats out, beat 64 tlast=1 tuser=1, frame_trunc one pulse, remaining 36 beats accepted and dropped, then IDLE.
REQ-031 Port 3 sends exactly 64-beat frame with MAX_FRAME_LEN=64 -> no truncation, frame_trunc 0, tuser follows input.
REQ-032 Random m_axis_tready backpressure (50%) on 2-port traffic -> byte stream per frame matches input exactly, tready to non-granted port always 0.
REQ-033 rst asserted at beat 5 of a frame on port 1 -> next cycle grant 0, busy 0, m_axis_tvalid 0; after release port 0 request granted first (rr_ptr 0).
